// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and move-FSM state type for the frame timing block.
// Defaults describe the standard 640x480 @ 60 Hz raster from a 100 MHz clock.
package vga_timing_pkg;

    localparam int PIX_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = timing_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = timing_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Move point sits on the first blanked line so movers have finished the visible frame.
    localparam int MOVE_H = 0;
    localparam int MOVE_V = V_VISIBLE_DEF;

    typedef enum logic [1:0] {
        MV_FROZEN = 2'd0,
        MV_WAIT   = 2'd1,
        MV_FIRE   = 2'd2
    } move_state_t;

endpackage

// File: rtl/vga_frame_timing_if.sv
// Control inputs and raster/timing outputs of the VGA frame timing block.
// master = timing generator, slave = consumer (movers, pin driver).
interface vga_frame_timing_if;
    logic       run;
    logic [3:0] speed;
    logic       pixpulse;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       frame_start;
    logic       move;

    modport master (
        input  run, speed,
        output pixpulse, hcount, vcount, hsync, vsync, blank, frame_start, move
    );

    modport slave (
        output run, speed,
        input  pixpulse, hcount, vcount, hsync, vsync, blank, frame_start, move
    );
endinterface

// File: rtl/pixel_tick_div.sv
// Divides clk by PIX_DIV into a registered one-clk pixel strobe.
// The strobe is high while the divider sits on its last count.
module pixel_tick_div #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixpulse
);
    localparam int CW = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] pix_cnt_next;

    always_comb begin
        pix_cnt_next = (pix_cnt == LAST) ? '0 : pix_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt  <= '0;
            pixpulse <= 1'b0;
        end else begin
            pix_cnt  <= pix_cnt_next;
            pixpulse <= (pix_cnt_next == LAST);
        end
    end
endmodule

// File: rtl/vga_frame_timing.sv
// VGA raster scan with registered sync/blank decodes and a frame-rate move strobe.
// All raster outputs advance on the clk edge where pixpulse is high.
//
// Move FSM states:
//   state     | meaning
//   MV_FROZEN | run low, frame counter held at zero, no move
//   MV_WAIT   | running, counting move points until frame_cnt >= speed
//   MV_FIRE   | move high for the pixel period of the move point
module vga_frame_timing
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input logic                clk,
    input logic                rst,
    vga_frame_timing_if.master bus
);
    localparam int H_TOT = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] MOVE_X   = 10'(MOVE_H);
    localparam logic [9:0] MOVE_Y   = 10'(V_VISIBLE);

    logic       pixpulse;
    logic [9:0] hcount, vcount;
    logic [9:0] h_next, v_next;
    logic       hsync, vsync, blank, frame_start;
    logic       at_move_point;

    move_state_t state, state_next;
    logic [3:0]  frame_cnt, frame_cnt_next;

    pixel_tick_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pixel_tick_div (
        .clk      (clk),
        .rst      (rst),
        .pixpulse (pixpulse)
    );

    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            h_next = hcount + 10'd1;
        end
    end

    // Decodes are computed from the incoming position so they stay aligned with the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b1;
        end else if (pixpulse) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= !((h_next >= HS_BEGIN) && (h_next < HS_END));
            vsync       <= !((v_next >= VS_BEGIN) && (v_next < VS_END));
            blank       <= (h_next >= H_VIS) || (v_next >= V_VIS);
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

    assign at_move_point = pixpulse && (h_next == MOVE_X) && (v_next == MOVE_Y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MV_FROZEN;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        case (state)
            MV_FIRE: begin
                // Hold the strobe through exactly one pixpulse, then resume counting.
                if (!bus.run) frame_cnt_next = '0;
                if (pixpulse) state_next = bus.run ? MV_WAIT : MV_FROZEN;
            end
            default: begin
                if (!bus.run) begin
                    state_next     = MV_FROZEN;
                    frame_cnt_next = '0;
                end else begin
                    state_next = MV_WAIT;
                    if (at_move_point) begin
                        if (frame_cnt >= bus.speed) begin
                            state_next     = MV_FIRE;
                            frame_cnt_next = '0;
                        end else begin
                            frame_cnt_next = frame_cnt + 4'd1;
                        end
                    end
                end
            end
        endcase
    end

    assign bus.pixpulse    = pixpulse;
    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    assign bus.blank       = blank;
    assign bus.frame_start = frame_start;
    assign bus.move        = (state == MV_FIRE);

endmodule

// File: tb/tb_vga_frame_timing.sv
// Bench for vga_frame_timing on a reduced raster; expected outputs come from clock-count arithmetic.
module tb_vga_frame_timing;
    localparam int P  = 4;
    localparam int HV = 20, HF = 3, HS = 4, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int F  = HT * VT * P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_frame_timing_if bus ();

    vga_frame_timing #(
        .PIX_DIV (P),
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int cnt_m  = 0;
    bit mv_m   = 1'b0;

    localparam logic [25:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    function automatic int eh();
        return (k / P) % HT;
    endfunction

    function automatic int ev();
        return (k / (P * HT)) % VT;
    endfunction

    function automatic logic [25:0] exp_vec();
        int  h = eh();
        int  v = ev();
        bit  pp = ((k % P) == P - 1);
        bit  hs = !(h >= HV + HF && h < HV + HF + HS);
        bit  vs = !(v >= VV + VF && v < VV + VF + VS);
        bit  bl = (h >= HV) || (v >= VV);
        bit  fs = (h == 0) && (v == 0);
        return {pp, 10'(h), 10'(v), hs, vs, bl, fs, mv_m};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {bus.pixpulse, bus.hcount, bus.vcount, bus.hsync, bus.vsync,
                bus.blank, bus.frame_start, bus.move};
    endfunction

    // Advance one clk and update the model: a move fires at (0,VV) when run and enough frames passed.
    task automatic step();
        @(posedge clk);
        k++;
        if (k % P == 0) begin
            mv_m = 1'b0;
            if (eh() == 0 && ev() == VV && bus.run) begin
                if (cnt_m >= int'(bus.speed)) begin
                    mv_m  = 1'b1;
                    cnt_m = 0;
                end else begin
                    cnt_m++;
                end
            end
        end
        if (!bus.run) cnt_m = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [25:0] o;
        rst       = 1'b0;
        bus.run   = 1'b0;
        bus.speed = 4'd0;
        repeat (3) begin
            @(negedge clk);
            o = obs_vec();
            checks++;
            if (o !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_hold got=%h exp=%h", o, RESET_VEC);
            end
        end
    endtask

    task automatic test_pixel_divider();
        logic [25:0] o, e;
        rst = 1'b1;
        k = 0; cnt_m = 0; mv_m = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL divider k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    task automatic test_raster_frame();
        logic [25:0] o, e;
        bit prev_fs;
        int rise0 = -1, rise1 = -1;
        prev_fs = bus.frame_start;
        for (int i = 0; i < 2 * F + 8; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL raster k=%0d got=%h exp=%h", k, o, e);
            end
            if (bus.frame_start && !prev_fs) begin
                if (rise0 < 0) rise0 = k; else if (rise1 < 0) rise1 = k;
            end
            prev_fs = bus.frame_start;
        end
        checks++;
        if (rise0 < 0 || rise1 < 0 || (rise1 - rise0) != F) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", rise1 - rise0, F);
        end
    endtask

    task automatic test_sync_blank();
        logic [25:0] o, e;
        int hs_low_line0 = 0, vs_low = 0;
        for (int i = 0; i < F; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sync_blank k=%0d h=%0d v=%0d got=%h exp=%h", k, eh(), ev(), o, e);
            end
            if (!bus.hsync && ev() == 0) hs_low_line0++;
            if (!bus.vsync) vs_low++;
        end
        checks++;
        if (hs_low_line0 != HS * P) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=%0d", hs_low_line0, HS * P);
        end
        checks++;
        if (vs_low != VS * HT * P) begin
            errors++;
            $display("FAIL vsync_width got=%0d exp=%0d", vs_low, VS * HT * P);
        end
    endtask

    task automatic test_move_every_frame();
        logic [25:0] o, e;
        int move_clks = 0, move_pps = 0, move_visible = 0;
        bus.run   = 1'b1;
        bus.speed = 4'd0;
        for (int i = 0; i < 3 * F; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL move_speed0 k=%0d got=%h exp=%h", k, o, e);
            end
            if (bus.move) begin
                move_clks++;
                if (bus.pixpulse) move_pps++;
                if (!bus.blank) move_visible++;
            end
        end
        checks++;
        if (move_clks != 3 * P || move_pps != 3) begin
            errors++;
            $display("FAIL move_width clks=%0d pps=%0d exp_clks=%0d exp_pps=3", move_clks, move_pps, 3 * P);
        end
        checks++;
        if (move_visible != 0) begin
            errors++;
            $display("FAIL move_in_visible got=%0d exp=0", move_visible);
        end
    endtask

    task automatic test_speed_change();
        logic [25:0] o, e;
        int moves = 0, pm, k_exp, first = -1;
        bus.speed = 4'd3;
        for (int i = 0; i < 6 * F; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL move_speed3 k=%0d got=%h exp=%h", k, o, e);
            end
            if (bus.move && bus.pixpulse) moves++;
        end
        checks++;
        if (moves != 1) begin
            errors++;
            $display("FAIL speed3_moves got=%0d exp=1", moves);
        end
        bus.speed = 4'd0;
        pm = ((k / P) / (HT * VT)) * (HT * VT) + VV * HT;
        if (pm <= k / P) pm += HT * VT;
        k_exp = pm * P;
        for (int i = 0; i < F + 8 && first < 0; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL speed_drop k=%0d got=%h exp=%h", k, o, e);
            end
            if (bus.move) first = k;
        end
        checks++;
        if (first != k_exp) begin
            errors++;
            $display("FAIL speed_drop_first_move got=%0d exp=%0d", first, k_exp);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [25:0] o, e;
        int first = -1;
        bus.run   = 1'b1;
        bus.speed = 4'd0;
        for (int i = 0; i < F && !(eh() == HV / 2 && ev() == VV / 2 && k % P == 1); i++) step();
        rst = 1'b0;
        #1;
        o = obs_vec();
        checks++;
        if (o !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", o, RESET_VEC);
        end
        repeat (3) begin
            @(negedge clk);
            o = obs_vec();
            checks++;
            if (o !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_mid_hold got=%h exp=%h", o, RESET_VEC);
            end
        end
        rst = 1'b1;
        k = 0; cnt_m = 0; mv_m = 1'b0;
        for (int i = 0; i < F + 8 && first < 0; i++) begin
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", k, o, e);
            end
            if (bus.move) first = k;
        end
        checks++;
        if (first != VV * HT * P) begin
            errors++;
            $display("FAIL first_move_after_reset got=%0d exp=%0d", first, VV * HT * P);
        end
    endtask

    task automatic test_random_run_speed();
        logic [25:0] o, e;
        int hold = 0;
        for (int i = 0; i < 6 * F; i++) begin
            if (hold == 0) begin
                bus.run   = ($urandom % 4) != 0;
                bus.speed = 4'($urandom % 4);
                hold      = $urandom_range(1, 3 * F / 2);
            end
            hold--;
            step();
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random k=%0d run=%0b speed=%0d got=%h exp=%h", k, bus.run, bus.speed, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pixel_divider();
        test_raster_frame();
        test_sync_blank();
        test_move_every_frame();
        test_speed_change();
        test_mid_frame_reset();
        test_random_run_speed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
